pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
- Game sequencer for the pong LED-matrix design; sits between the 1 kHz game-tick generator, the ball block and the screen driver.
- Tracks ball position against both paddles on each game tick and decides hit or miss.
- Owns the score, the rally speed-up and the serve/point/game-over sequence.
- Drives the speed and hold inputs of the ball block and the score/status inputs of the screen.

Parameters:
PADDLE_LEN, 3, paddle height in rows (1..8).
SERVE_TICKS, 500, game ticks the ball is held before each serve.
POINT_TICKS, 1000, game ticks of the post-point pause.
WIN_SCORE, 9, score that ends the game (1..15).
SPEED_INIT, 1, ball speed at each serve.
SPEED_MAX, 7, speed ceiling (≤15).
HITS_PER_UP, 4, paddle hits per speed increment.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk game-tick strobe (1 kHz)
start  in  1  synchronised start button, level
ball_x  in  4  ball column 0..15
ball_y  in  4  ball row 0..15
pad_l_y  in  4  left paddle top row
pad_r_y  in  4  right paddle top row
speed  out  5  signed ball speed to ball block
ball_hold  out  1  1 = ball frozen at centre
serve_dir  out  1  0 = serve toward left, 1 = toward right
score_l  out  4  left score
score_r  out  4  right score
state  out  3  FSM state code for screen/debug
winner  out  1  valid in GAMEOVER: 0 = left, 1 = right

Behaviour:
- All state updates on rising clk. reset low asynchronously forces:
  - state = IDLE(0), speed = 0, ball_hold = 1, serve_dir = 0;
  - scores 0, winner 0, tick counter 0, hit counter 0.
- Reset asserted mid-operation aborts immediately to these values.
- States and codes: IDLE 0, SERVE 1, PLAY 2, POINT 3, GAMEOVER 4; codes 5–7 unused and return to IDLE next clk.
- IDLE:
  - Outputs: ball_hold = 1, speed = 0.
  - start = 1 → SERVE next clk; scores cleared, counter loaded with SERVE_TICKS.
- SERVE:
  - Outputs: ball_hold = 1, speed = 0.
  - Counter decrements on tick only.
  - On the tick where counter = 1 → PLAY. Outputs: speed = SPEED_INIT, ball_hold = 0, hit counter cleared.
- PLAY:
  - Outputs: ball_hold = 0. Evaluation happens only on clks with tick = 1.
  - Left edge: when ball_x = 0, it is a hit if pad_l_y ≤ ball_y ≤ pad_l_y+PADDLE_LEN-1. Compare in 5 bits so that pad_y+LEN never wraps past 15.
  - Right edge: the same rule for ball_x = 15 with pad_r_y.
  - Hit:
    - hit counter +1.
    - When the count reaches HITS_PER_UP, clear it and increment speed, saturating at SPEED_MAX.
    - State stays PLAY.
  - Miss:
    - Opponent score +1, saturating at 15. A miss at x = 0 scores right; a miss at x = 15 scores left.
    - serve_dir is set toward the player who lost the point: x = 0 → 0, x = 15 → 1.
    - speed = 0, ball_hold = 1.
    - If the new score = WIN_SCORE → GAMEOVER with winner set. Otherwise → POINT, counter = POINT_TICKS.
  - ball_x not 0 or 15, or tick = 0: no change.
- POINT:
  - Outputs: ball_hold = 1, speed = 0.
  - Counter counts down on tick; at 1 → SERVE, counter = SERVE_TICKS. Scores are kept.
- GAMEOVER:
  - Outputs: ball_hold = 1, speed = 0; scores and winner frozen.
  - Requires a rising edge of start (start = 1 with previous-clk start = 0) → IDLE.
  - A start held high from the previous game does not retrigger.
- Simultaneous events:
  - tick and start in IDLE: start wins. The tick is not counted toward SERVE.
  - start is ignored in SERVE, PLAY and POINT.
- speed is always 0..SPEED_MAX, registered, and changes only on the tick/clk edges above.
- Latency:
  - The state change, and every output change caused by a tick, become visible on the clk after the tick-qualified edge.
  - No combinational path from any input to any output.

Test Plan:
- Reset sequence: reset low for 3 clks, release, start = 1 for 1 clk. Required: state 0→1, ball_hold = 1, speed = 0. After 500 ticks: state = 2, speed = 1, ball_hold = 0.
- Left hit: PLAY, pad_l_y = 5, ball_x = 0, ball_y = 7, tick. Required: stays PLAY, scores unchanged. After 4 such hits speed = 2. After 28 hits speed saturates at 7.
- Paddle edge cases: pad_r_y = 14, ball_x = 15. ball_y = 15 → hit. ball_y = 13 → miss: score_l = 1, serve_dir = 1, state = POINT, speed = 0. After 1000 ticks state = SERVE.
- Game end and restart:
  - Preset score_r = 8, then miss at x = 0. Required: score_r = 9, state = GAMEOVER, winner = 1.
  - start held high gives no change. Release then press start: state = IDLE.
  - Next start clears both scores.
- Reset mid-play: reset pulse low while in PLAY with speed = 3. Required: all outputs at reset values asynchronously, before the next clk edge.
- Simultaneous tick and start in IDLE: state = SERVE and the SERVE counter still reads 500.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the pong LED matrix (serve, rally, scoring, game over)
// Ports:
//    clk, reset      system clock, asynchronous active-low reset
//    tick            one-clk 1 kHz game-tick strobe
//    start           synchronised start button level
//    ball_x, ball_y  ball column / row
//    pad_l_y/pad_r_y top row of left / right paddle
//    speed           ball speed to ball block (0..SPEED_MAX)
//    ball_hold       1 = ball frozen at centre
//    serve_dir       0 = serve toward left, 1 = toward right
//    score_l/score_r scores
//    state           FSM state code
//    winner          valid in GAMEOVER: 0 = left, 1 = right
module pong_game_ctrl #(
   parameter int PADDLE_LEN  = 3,
   parameter int SERVE_TICKS = 500,
   parameter int POINT_TICKS = 1000,
   parameter int WIN_SCORE   = 9,
   parameter int SPEED_INIT  = 1,
   parameter int SPEED_MAX   = 7,
   parameter int HITS_PER_UP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic [3:0] ball_x,
   input  logic [3:0] ball_y,
   input  logic [3:0] pad_l_y,
   input  logic [3:0] pad_r_y,
   output logic [4:0] speed,
   output logic       ball_hold,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [2:0] state,
   output logic       winner
);
   localparam int CW = $clog2((SERVE_TICKS > POINT_TICKS ? SERVE_TICKS : POINT_TICKS) + 1);
   localparam int HW = $clog2(HITS_PER_UP + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, GAMEOVER = 3'd4} st_t;
   st_t st;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hits;
   logic start_q;
   logic [4:0] y5;
   logic hit_l, hit_r, lside, at_edge, hit;
   logic [3:0] sc_n;
   assign state = st;
   // 5-bit compare so a paddle near the bottom never wraps its range past row 15
   assign y5 = {1'b0, ball_y};
   assign hit_l = y5 >= {1'b0, pad_l_y} && y5 <= {1'b0, pad_l_y} + 5'(PADDLE_LEN - 1);
   assign hit_r = y5 >= {1'b0, pad_r_y} && y5 <= {1'b0, pad_r_y} + 5'(PADDLE_LEN - 1);
   assign lside = ball_x == 4'd0;
   assign at_edge = lside || ball_x == 4'd15;
   assign hit = lside ? hit_l : hit_r;
   // score of the opponent of the side that missed, saturated at 15
   assign sc_n = lside ? (score_r == 4'd15 ? 4'd15 : score_r + 4'd1)
                       : (score_l == 4'd15 ? 4'd15 : score_l + 4'd1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= IDLE;
         speed <= '0;
         ball_hold <= 1'b1;
         serve_dir <= 1'b0;
         score_l <= '0;
         score_r <= '0;
         winner <= 1'b0;
         cnt <= '0;
         hits <= '0;
         start_q <= 1'b0;
      end else begin
         start_q <= start;
         case (st)
            IDLE: begin
               ball_hold <= 1'b1;
               speed <= '0;
               if (start) begin
                  st <= SERVE;
                  score_l <= '0;
                  score_r <= '0;
                  cnt <= CW'(SERVE_TICKS);
               end
            end
            SERVE: begin
               ball_hold <= 1'b1;
               speed <= '0;
               if (tick) begin
                  if (cnt == CW'(1)) begin
                     st <= PLAY;
                     speed <= 5'(SPEED_INIT);
                     ball_hold <= 1'b0;
                     hits <= '0;
                  end else cnt <= cnt - 1'b1;
               end
            end
            PLAY: begin
               if (tick && at_edge) begin
                  if (hit) begin
                     if (hits == HW'(HITS_PER_UP - 1)) begin
                        hits <= '0;
                        speed <= speed < 5'(SPEED_MAX) ? speed + 5'd1 : speed;
                     end else hits <= hits + 1'b1;
                  end else begin
                     speed <= '0;
                     ball_hold <= 1'b1;
                     serve_dir <= !lside;
                     cnt <= CW'(POINT_TICKS);
                     if (lside) score_r <= sc_n;
                     else score_l <= sc_n;
                     if (sc_n == 4'(WIN_SCORE)) begin
                        st <= GAMEOVER;
                        winner <= lside;
                     end else st <= POINT;
                  end
               end
            end
            POINT: begin
               ball_hold <= 1'b1;
               speed <= '0;
               if (tick) begin
                  if (cnt == CW'(1)) begin
                     st <= SERVE;
                     cnt <= CW'(SERVE_TICKS);
                  end else cnt <= cnt - 1'b1;
               end
            end
            GAMEOVER: begin
               ball_hold <= 1'b1;
               speed <= '0;
               if (start && !start_q) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
